// File: rtl/msrv32_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_ahb_arbiter
// Description : Shares one AHB-Lite master port between fetch and load/store,
//               data-priority with a bounded fetch-starvation streak.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_ahb_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 2
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_rdata_out,
  output logic              if_ready_out,
  input  logic              dm_req_in,
  input  logic              dm_wr_in,
  input  logic [1:0]        dm_size_in,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic [DATA_W-1:0] dm_wdata_in,
  output logic [DATA_W-1:0] dm_rdata_out,
  output logic              dm_ready_out,
  output logic              dm_err_out,
  output logic              if_err_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic [1:0]        htrans_out,
  output logic              hwrite_out,
  output logic [2:0]        hsize_out,
  output logic [DATA_W-1:0] hwdata_out,
  input  logic [DATA_W-1:0] hrdata_in,
  input  logic              hready_in,
  input  logic              hresp_in
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_DATA = 2'd1,
    DM_DATA = 2'd2
  } state_t;

  localparam logic [3:0] c_max_streak = 4'(MAX_DM_STREAK);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_streak;
  logic [3:0]        w_next_streak;
  logic              r_dm_wr;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic              r_if_err;
  logic              r_dm_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [DATA_W-1:0] r_hwdata;
  logic              w_arb_ok;
  logic              w_grant_if;
  logic              w_grant_dm;

  // The cycle carrying a ready pulse is the bubble: requesters still hold
  // their request then, so granting would duplicate the finished access.
  always_comb begin
    w_arb_ok   = (r_state == IDLE) && hready_in && ms_riscv32_mp_rst_in &&
                 !r_if_ready && !r_dm_ready;
    w_grant_dm = w_arb_ok && dm_req_in && (!if_req_in || (r_streak != c_max_streak));
    w_grant_if = w_arb_ok && if_req_in && !w_grant_dm;
  end

  always_comb begin
    htrans_out = 2'b00;
    haddr_out  = '0;
    hwrite_out = 1'b0;
    hsize_out  = 3'b010;
    if (w_grant_dm) begin
      htrans_out = 2'b10;
      haddr_out  = dm_addr_in;
      hwrite_out = dm_wr_in;
      hsize_out  = (dm_size_in == 2'b11) ? 3'b010 : {1'b0, dm_size_in};
    end else if (w_grant_if) begin
      htrans_out = 2'b10;
      haddr_out  = if_addr_in;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_streak = r_streak;
    case (r_state)
      IDLE: begin
        if (w_grant_dm) begin
          w_next_state = DM_DATA;
          if (!if_req_in)
            w_next_streak = 4'd0;
          else if (r_streak != c_max_streak)
            w_next_streak = r_streak + 4'd1;
        end else if (w_grant_if) begin
          w_next_state  = IF_DATA;
          w_next_streak = 4'd0;
        end
      end
      IF_DATA, DM_DATA: begin
        if (hready_in)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      r_state    <= IDLE;
      r_streak   <= 4'd0;
      r_dm_wr    <= 1'b0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_err   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_hwdata   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_streak   <= w_next_streak;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_err   <= 1'b0;
      if (w_grant_dm) begin
        r_hwdata <= dm_wdata_in;
        r_dm_wr  <= dm_wr_in;
      end
      // ERROR completes on its second cycle; rdata is left untouched.
      if (hready_in) begin
        if (r_state == IF_DATA) begin
          r_if_ready <= 1'b1;
          r_if_err   <= hresp_in;
          if (!hresp_in)
            r_if_rdata <= hrdata_in;
        end else if (r_state == DM_DATA) begin
          r_dm_ready <= 1'b1;
          r_dm_err   <= hresp_in;
          if (!hresp_in && !r_dm_wr)
            r_dm_rdata <= hrdata_in;
        end
      end
    end
  end

  assign if_ready_out = r_if_ready;
  assign dm_ready_out = r_dm_ready;
  assign if_err_out   = r_if_err;
  assign dm_err_out   = r_dm_err;
  assign if_rdata_out = r_if_rdata;
  assign dm_rdata_out = r_dm_rdata;
  assign hwdata_out   = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_ahb_arbiter.sv
`default_nettype none
// Bench for msrv32_ahb_arbiter: table of single transfers plus directed
// sequences for IDLE stall, contention, and reset mid-transfer.
module tb_msrv32_ahb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_wr;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_err;
  logic        if_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int errors = 0;
  int checks = 0;

  msrv32_ahb_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(2)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .if_req_in(if_req),
    .if_addr_in(if_addr),
    .if_rdata_out(if_rdata),
    .if_ready_out(if_ready),
    .dm_req_in(dm_req),
    .dm_wr_in(dm_wr),
    .dm_size_in(dm_size),
    .dm_addr_in(dm_addr),
    .dm_wdata_in(dm_wdata),
    .dm_rdata_out(dm_rdata),
    .dm_ready_out(dm_ready),
    .dm_err_out(dm_err),
    .if_err_out(if_err),
    .haddr_out(haddr),
    .htrans_out(htrans),
    .hwrite_out(hwrite),
    .hsize_out(hsize),
    .hwdata_out(hwdata),
    .hrdata_in(hrdata),
    .hready_in(hready),
    .hresp_in(hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          waits;
    bit          err;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transfer: grant cycle N, data phase with waits, ready at end.
  task automatic do_xfer(input vec_t v);
    @(negedge clk);
    hready = 1'b1;
    hresp  = 1'b0;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_wr = v.wr; dm_size = v.size;
      dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk("grant_htrans", 32'(htrans), 32'h2);
    chk("grant_haddr", haddr, v.addr);
    chk("grant_hwrite", 32'(hwrite), 32'(v.is_dm & v.wr));
    chk("grant_hsize", 32'(hsize), 32'(v.exp_hsize));
    for (int w = 0; w < v.waits; w++) begin
      @(negedge clk);
      hready = 1'b0;
      hresp  = v.err;
      #1;
      chk("wait_htrans", 32'(htrans), 32'h0);
      chk("wait_ready", 32'({if_ready, dm_ready}), 32'h0);
      if (v.is_dm && v.wr) chk("wait_hwdata", hwdata, v.wdata);
    end
    @(negedge clk);
    hready = 1'b1;
    hresp  = v.err;
    hrdata = v.hrdata;
    #1;
    chk("phase_htrans", 32'(htrans), 32'h0);
    chk("phase_ready", 32'({if_ready, dm_ready}), 32'h0);
    @(negedge clk);
    hresp = 1'b0;
    #1;
    chk("bubble_htrans", 32'(htrans), 32'h0);
    if (v.is_dm) begin
      chk("dm_ready", 32'(dm_ready), 32'h1);
      chk("if_ready_idle", 32'(if_ready), 32'h0);
      chk("dm_err", 32'(dm_err), 32'(v.err));
      chk("dm_rdata", dm_rdata, v.exp_rdata);
      if (v.wr) chk("hwdata", hwdata, v.wdata);
    end else begin
      chk("if_ready", 32'(if_ready), 32'h1);
      chk("dm_ready_idle", 32'(dm_ready), 32'h0);
      chk("if_err", 32'(if_err), 32'(v.err));
      chk("if_rdata", if_rdata, v.exp_rdata);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_pulse_end", 32'({if_ready, dm_ready, if_err, dm_err}), 32'h0);
  endtask

  vec_t       vtmp;
  logic [7:0] got_order[6];
  logic [7:0] exp_order[6];
  int         ngrant;

  initial begin
      //         dm wr size   addr           wdata          hrdata         w  err hsize   exp_rdata
    vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h0000_0013, 0, 1'b0, 3'b010, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 3, 1'b0, 3'b001, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h0000_3000, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 3'b010, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0,         32'hDEAD_DEAD, 1, 1'b1, 3'b010, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 32'h0000_5001, 32'h0,         32'h0000_00AB, 0, 1'b0, 3'b000, 32'h0000_00AB};
    vecs[5] = '{1'b1, 1'b0, 2'b11, 32'h0000_6000, 32'h0,         32'h1122_3344, 0, 1'b0, 3'b010, 32'h1122_3344};
    vecs[6] = '{1'b0, 1'b0, 2'b10, 32'h0000_0104, 32'h0,         32'h7777_7777, 1, 1'b1, 3'b010, 32'h0000_0013};
    vecs[7] = '{1'b0, 1'b0, 2'b10, 32'h0000_0108, 32'h0,         32'h00A0_0093, 2, 1'b0, 3'b010, 32'h00A0_0093};
    vecs[8] = '{1'b1, 1'b1, 2'b10, 32'h0000_7000, 32'hA5A5_5A5A, 32'h0,         0, 1'b0, 3'b010, 32'h1122_3344};

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_size = 2'b10; dm_addr = '0; dm_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    #2;
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hsize", 32'(hsize), 32'h2);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    chk("rst_flags", 32'({if_ready, dm_ready, if_err, dm_err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_xfer(vecs[i]);

    // hready low in IDLE blocks the grant
    @(negedge clk);
    hready = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_htrans", 32'(htrans), 32'h0);
      @(negedge clk);
    end
    hready = 1'b1; hrdata = 32'h0BAD_F00D;
    #1;
    chk("stall_grant_htrans", 32'(htrans), 32'h2);
    chk("stall_grant_haddr", haddr, 32'h0000_0200);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stall_if_ready", 32'(if_ready), 32'h1);
    chk("stall_if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0;
    @(negedge clk);

    // contention: D,D,I,D,D,I
    exp_order = '{8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h49};
    got_order = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    if_req = 1'b1; if_addr = 32'h0000_0800;
    dm_req = 1'b1; dm_wr = 1'b0; dm_size = 2'b10; dm_addr = 32'h0000_0900;
    hrdata = 32'h0; ngrant = 0;
    for (int c = 0; c < 40 && ngrant < 6; c++) begin
      #1;
      if (htrans == 2'b10) begin
        got_order[ngrant] = (haddr == 32'h0000_0900) ? 8'h44 : 8'h49;
        ngrant++;
      end
      @(negedge clk);
    end
    for (int g = 0; g < 6; g++) chk($sformatf("contention_grant%0d", g), 32'(got_order[g]), 32'(exp_order[g]));
    @(negedge clk);
    #1;
    chk("contention_last_if_ready", 32'(if_ready), 32'h1);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

    // reset in the data phase of a load
    hready = 1'b1;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h0000_0A00;
    #1;
    chk("rstmid_grant", 32'(htrans), 32'h2);
    @(negedge clk);
    hready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_htrans", 32'(htrans), 32'h0);
    chk("rstmid_haddr", haddr, 32'h0);
    chk("rstmid_hsize", 32'(hsize), 32'h2);
    chk("rstmid_hwdata", hwdata, 32'h0);
    chk("rstmid_rdata", if_rdata | dm_rdata, 32'h0);
    hready = 1'b1; hrdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rstmid_no_ready", 32'({if_ready, dm_ready, dm_err}), 32'h0);
      chk("rstmid_no_grant", 32'(htrans), 32'h0);
    end
    dm_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_after_ready", 32'({if_ready, dm_ready}), 32'h0);
    vtmp = '{1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0, 32'h0000_0055, 0, 1'b0, 3'b010, 32'h0000_0055};
    do_xfer(vtmp);
    chk("rstmid_dm_rdata_kept", dm_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
